// File: rtl/bit_plane_streamer.sv
// Streams a parallel vector out as DATA_WIDTH bit-planes, one plane per cycle; first plane one cycle after accept.
// Backpressure: stalled planes hold; one pending slot lets the next vector load while the current one streams.
module bit_plane_streamer #(
    parameter int DATA_WIDTH = 8,
    parameter int VEC_LENGTH = 16,
    parameter bit MSB_FIRST  = 1'b1,
    localparam int IW        = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] d_in [VEC_LENGTH],
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [VEC_LENGTH-1:0] bit_out,
    output logic [IW-1:0]         bit_idx,
    output logic                  out_first,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy
);

    typedef enum logic {S_EMPTY = 1'b0, S_STREAM = 1'b1} state_t;

    localparam logic [IW-1:0] LAST_CNT = IW'(DATA_WIDTH - 1);

    state_t                state_q, state_d;
    logic [IW-1:0]         cnt_q, cnt_d;
    logic                  pend_full_q, pend_full_d;
    logic [VEC_LENGTH-1:0] sreg_q [DATA_WIDTH];
    logic [VEC_LENGTH-1:0] sreg_d [DATA_WIDTH];
    logic [VEC_LENGTH-1:0] load_planes [DATA_WIDTH];
    logic [VEC_LENGTH-1:0] shifted [DATA_WIDTH];
    logic [DATA_WIDTH-1:0] pend_q [VEC_LENGTH];
    logic [DATA_WIDTH-1:0] pend_d [VEC_LENGTH];
    logic [DATA_WIDTH-1:0] src [VEC_LENGTH];

    logic in_fire, out_fire, last_fire, take_pend, load_active, to_pending;

    assign in_ready    = !reset && !pend_full_q;
    assign in_fire     = in_valid && in_ready;
    assign out_fire    = out_valid && out_ready;
    assign last_fire   = out_fire && out_last;
    assign take_pend   = last_fire && pend_full_q;
    // in_fire during a last-plane fire implies the pending slot is empty
    assign load_active = (state_q == S_EMPTY && in_fire) || take_pend || (last_fire && in_fire);
    assign to_pending  = in_fire && (state_q == S_STREAM) && !last_fire;

    always_comb begin
        src = d_in;
        if (take_pend) src = pend_q;
    end

    // Transpose into emission order so the current plane always sits at index 0
    for (genvar k = 0; k < DATA_WIDTH; k++) begin : g_plane
        localparam int B = MSB_FIRST ? (DATA_WIDTH - 1 - k) : k;
        for (genvar j = 0; j < VEC_LENGTH; j++) begin : g_lane
            assign load_planes[k][j] = src[j][B];
        end
    end

    for (genvar k = 0; k < DATA_WIDTH - 1; k++) begin : g_shift
        assign shifted[k] = sreg_q[k+1];
    end
    assign shifted[DATA_WIDTH-1] = '0;

    always_comb begin
        sreg_d      = sreg_q;
        cnt_d       = cnt_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        if (load_active) begin
            sreg_d = load_planes;
            cnt_d  = '0;
        end else if (out_fire && !out_last) begin
            sreg_d = shifted;
            cnt_d  = cnt_q + IW'(1);
        end
        if (to_pending) begin
            pend_d      = d_in;
            pend_full_d = 1'b1;
        end else if (take_pend) begin
            pend_full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= '0;
            pend_full_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            pend_full_q <= pend_full_d;
        end
    end

    // Payload needs no reset: outputs are gated by state and pending_full guards pend_q
    always_ff @(posedge clk) begin
        sreg_q <= sreg_d;
        pend_q <= pend_d;
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_EMPTY;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_EMPTY:  if (in_fire) state_d = S_STREAM;
            S_STREAM: if (last_fire && !load_active) state_d = S_EMPTY;
            default:  state_d = S_EMPTY;
        endcase
    end

    always_comb begin
        out_valid = (state_q == S_STREAM);
        out_first = out_valid && (cnt_q == '0);
        out_last  = out_valid && (cnt_q == LAST_CNT);
        bit_out   = out_valid ? sreg_q[0] : '0;
        bit_idx   = '0;
        if (out_valid) bit_idx = MSB_FIRST ? (LAST_CNT - cnt_q) : cnt_q;
        busy      = out_valid || pend_full_q;
    end

endmodule

// File: tb/tb_bit_plane_streamer.sv
// Bench for bit_plane_streamer: scoreboarded plane stream plus directed protocol checks.
module tb_bit_plane_streamer;

    localparam int DW = 8;
    localparam int VL = 16;

    typedef struct packed {
        logic [VL-1:0] plane;
        logic [2:0]    idx;
        logic          first;
        logic          last;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset, in_valid, out_ready;
    logic [DW-1:0] d_in [VL];
    logic          in_ready, out_first, out_last, out_valid, busy;
    logic [VL-1:0] bit_out;
    logic [2:0]    bit_idx;

    logic          in_valid1, in_ready1, out_first1, out_last1, out_valid1, busy1;
    logic [VL-1:0] bit_out1;
    logic [2:0]    bit_idx1;

    logic [0:0]    d_in2 [VL];
    logic          in_valid2, in_ready2, out_first2, out_last2, out_valid2, busy2;
    logic [VL-1:0] bit_out2;
    logic [0:0]    bit_idx2;

    exp_t q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    bit_plane_streamer #(.DATA_WIDTH(DW), .VEC_LENGTH(VL), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .reset(reset), .d_in(d_in), .in_valid(in_valid), .in_ready(in_ready),
        .bit_out(bit_out), .bit_idx(bit_idx), .out_first(out_first), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy));

    bit_plane_streamer #(.DATA_WIDTH(DW), .VEC_LENGTH(VL), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .reset(reset), .d_in(d_in), .in_valid(in_valid1), .in_ready(in_ready1),
        .bit_out(bit_out1), .bit_idx(bit_idx1), .out_first(out_first1), .out_last(out_last1),
        .out_valid(out_valid1), .out_ready(out_ready), .busy(busy1));

    bit_plane_streamer #(.DATA_WIDTH(1), .VEC_LENGTH(VL), .MSB_FIRST(1'b1)) dut_w1 (
        .clk(clk), .reset(reset), .d_in(d_in2), .in_valid(in_valid2), .in_ready(in_ready2),
        .bit_out(bit_out2), .bit_idx(bit_idx2), .out_first(out_first2), .out_last(out_last2),
        .out_valid(out_valid2), .out_ready(out_ready), .busy(busy2));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [VL-1:0] plane_of(input int b);
        logic [VL-1:0] r;
        for (int j = 0; j < VL; j++) r[4'(j)] = d_in[4'(j)][3'(b)];
        return r;
    endfunction

    task automatic set_vec(input int kind);
        for (int j = 0; j < VL; j++)
            d_in[4'(j)] = (kind == 0) ? DW'(j + 1) : DW'((j * 37 + kind * 53 + 7) & 255);
    endtask

    task automatic push_exp();
        exp_t e;
        for (int p = 0; p < DW; p++) begin
            e.plane = plane_of(DW - 1 - p);
            e.idx   = 3'(DW - 1 - p);
            e.first = (p == 0);
            e.last  = (p == DW - 1);
            q.push_back(e);
        end
    endtask

    // Called #1 after a posedge; returns #1 after the accepting edge
    task automatic send(input int kind);
        int n;
        set_vec(kind);
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("send_accept", 32'(in_ready), 32'd1);
        push_exp();
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (out_valid !== 1'b0 && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_idle", 32'(out_valid), 32'd0);
        check("drain_sb_empty", 32'(q.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (q.size() == 0) begin
                check("extra_plane", 32'd1, 32'd0);
            end else begin
                mon_e = q.pop_front();
                check("sb_plane", 32'(bit_out), 32'(mon_e.plane));
                check("sb_idx", 32'(bit_idx), 32'(mon_e.idx));
                check("sb_first", 32'(out_first), 32'(mon_e.first));
                check("sb_last", 32'(out_last), 32'(mon_e.last));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [VL-1:0] hold_plane;
        logic [2:0]    hold_idx;
        logic          hold_first, hold_last;
        logic [VL-1:0] pat [6];
        int            n, vcount;

        reset = 1'b1; in_valid = 1'b0; in_valid1 = 1'b0; in_valid2 = 1'b0; out_ready = 1'b1;
        set_vec(0);
        for (int j = 0; j < VL; j++) d_in2[4'(j)] = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_bit_out", 32'(bit_out), 32'd0);
        check("rst_bit_idx", 32'(bit_idx), 32'd0);
        check("rst_valid_lsb", 32'(out_valid1), 32'd0);
        check("rst_valid_w1", 32'(out_valid2), 32'd0);
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // T1: single vector, words j+1
        send(0);
        check("t1_lat_valid", 32'(out_valid), 32'd1);
        check("t1_lat_idx", 32'(bit_idx), 32'd7);
        check("t1_lat_first", 32'(out_first), 32'd1);
        repeat (8) @(posedge clk);
        #1;
        check("t1_done_valid", 32'(out_valid), 32'd0);
        check("t1_done_busy", 32'(busy), 32'd0);
        check("t1_sb_empty", 32'(q.size()), 32'd0);

        // T2: back-to-back, second vector one cycle after the first
        send(1);
        send(2);
        check("t2_pend_in_ready", 32'(in_ready), 32'd0);
        check("t2_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            check("t2_no_gap", 32'(out_valid), 32'd1);
            check("t2_in_ready", 32'(in_ready), (i < 7) ? 32'd0 : 32'd1);
        end
        @(posedge clk); #1;
        check("t2_end_valid", 32'(out_valid), 32'd0);
        check("t2_sb_empty", 32'(q.size()), 32'd0);

        // T3: backpressure at bit_idx 5
        send(3);
        n = 0;
        while (bit_idx !== 3'd5 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("t3_reach_idx5", 32'(bit_idx), 32'd5);
        out_ready  = 1'b0;
        hold_plane = bit_out; hold_idx = bit_idx; hold_first = out_first; hold_last = out_last;
        repeat (3) begin
            @(posedge clk); #1;
            check("t3_hold_plane", 32'(bit_out), 32'(hold_plane));
            check("t3_hold_idx", 32'(bit_idx), 32'(hold_idx));
            check("t3_hold_first", 32'(out_first), 32'(hold_first));
            check("t3_hold_last", 32'(out_last), 32'(hold_last));
            check("t3_hold_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        drain();

        // T4: new vector offered in the last-plane cycle
        send(4);
        n = 0;
        while (out_last !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("t4_at_last", 32'(out_last), 32'd1);
        send(5);
        check("t4_next_valid", 32'(out_valid), 32'd1);
        check("t4_next_idx", 32'(bit_idx), 32'd7);
        check("t4_next_first", 32'(out_first), 32'd1);
        drain();

        // T5: reset mid-stream with pending full
        send(6);
        send(7);
        n = 0;
        while (bit_idx !== 3'd3 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("t5_reach_idx3", 32'(bit_idx), 32'd3);
        check("t5_pend_full", 32'(in_ready), 32'd0);
        out_ready = 1'b0;
        reset = 1'b1;
        q.delete();
        @(negedge clk);
        check("t5_rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("t5_valid", 32'(out_valid), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_bit_out", 32'(bit_out), 32'd0);
        check("t5_bit_idx", 32'(bit_idx), 32'd0);
        check("t5_first", 32'(out_first), 32'd0);
        check("t5_last", 32'(out_last), 32'd0);
        check("t5_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        vcount = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid !== 1'b0) vcount++;
        end
        check("t5_no_stale", 32'(vcount), 32'd0);
        @(posedge clk); #1;
        send(8);
        drain();

        // T6a: LSB-first build
        set_vec(9);
        in_valid1 = 1'b1;
        @(negedge clk);
        check("t6a_in_ready", 32'(in_ready1), 32'd1);
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        for (int p = 0; p < DW; p++) begin
            check("t6a_valid", 32'(out_valid1), 32'd1);
            check("t6a_idx", 32'(bit_idx1), 32'(p));
            check("t6a_plane", 32'(bit_out1), 32'(plane_of(p)));
            check("t6a_first", 32'(out_first1), (p == 0) ? 32'd1 : 32'd0);
            check("t6a_last", 32'(out_last1), (p == DW - 1) ? 32'd1 : 32'd0);
            @(posedge clk); #1;
        end
        check("t6a_end_valid", 32'(out_valid1), 32'd0);

        // T6b: single-bit words at one vector per cycle
        for (int i = 0; i < 6; i++) pat[i] = VL'((i + 1) * 16'h3A5B) ^ 16'hC30F;
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < VL; j++) d_in2[4'(j)] = pat[i][4'(j)];
            in_valid2 = 1'b1;
            @(negedge clk);
            check("t6b_in_ready", 32'(in_ready2), 32'd1);
            @(posedge clk); #1;
            check("t6b_valid", 32'(out_valid2), 32'd1);
            check("t6b_plane", 32'(bit_out2), 32'(pat[i]));
            check("t6b_first", 32'(out_first2), 32'd1);
            check("t6b_last", 32'(out_last2), 32'd1);
            check("t6b_idx", 32'(bit_idx2), 32'd0);
        end
        in_valid2 = 1'b0;
        @(posedge clk); #1;
        check("t6b_end_valid", 32'(out_valid2), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
